inv_linear: RTL and testbench



---
 rtl/inv_linear.sv | 113 +++++++++++
 tb/tb_inv_linear.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_linear.sv
// Iterative inverse of the ASCON linear diffusion layer.
// Applies L^(2^i) for i = 0..5 to all five words in parallel, one step per clock.
module inv_linear (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] IV,
    input  logic [63:0] k0,
    input  logic [63:0] k1,
    input  logic [63:0] n0,
    input  logic [63:0] n1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] oIV,
    output logic [63:0] ok0,
    output logic [63:0] ok1,
    output logic [63:0] on0,
    output logic [63:0] on1
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

    state_t      state;
    state_t      state_next;
    logic [2:0]  step;
    logic [63:0] work    [5];
    logic [63:0] res     [5];
    logic [63:0] stepped [5];

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Squaring in GF(2) doubles each rotation amount; truncating to 6 bits gives the mod 64.
    always_comb begin
        for (int s = 0; s < 5; s++) begin
            stepped[s] = work[s]
                       ^ ror64(work[s], 6'(ROT_A[s] << step))
                       ^ ror64(work[s], 6'(ROT_B[s] << step));
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (step == 3'd5) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are separate from the working set so outputs only move on step edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 3'd0;
            for (int s = 0; s < 5; s++) begin
                work[s] <= 64'd0;
                res[s]  <= 64'd0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work[0] <= IV;
                        work[1] <= k0;
                        work[2] <= k1;
                        work[3] <= n0;
                        work[4] <= n1;
                        step    <= 3'd0;
                    end
                end
                RUN: begin
                    for (int s = 0; s < 5; s++) begin
                        work[s] <= stepped[s];
                        res[s]  <= stepped[s];
                    end
                    step <= (step == 3'd5) ? 3'd0 : step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign oIV = res[0];
    assign ok0 = res[1];
    assign ok1 = res[2];
    assign on0 = res[3];
    assign on1 = res[4];

endmodule

// File: tb/tb_inv_linear.sv
// Randomised bench for inv_linear: results are checked against L^63 computed from the
// forward layer, against a forward round trip, and across stall/busy/reset scenarios.
module tb_inv_linear;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] IV = '0, k0 = '0, k1 = '0, n0 = '0, n1 = '0;
    logic [63:0] oIV, ok0, ok1, on0, on1;

    int total = 0;
    int bad = 0;

    logic [63:0] inW  [5];
    logic [63:0] expW [5];
    logic [63:0] got  [5];

    localparam int A_ROT [5] = '{19, 61, 1, 10, 7};
    localparam int B_ROT [5] = '{28, 39, 6, 17, 41};

    always #5 clk = ~clk;

    inv_linear dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .IV       (IV),
        .k0       (k0),
        .k1       (k1),
        .n0       (n0),
        .n1       (n1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .oIV      (oIV),
        .ok0      (ok0),
        .ok1      (ok1),
        .on0      (on0),
        .on1      (on1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rorModel(input logic [63:0] x, input int n);
        int m;
        m = n % 64;
        if (m == 0) return x;
        return (x >> m) | (x << (64 - m));
    endfunction

    function automatic logic [63:0] forwardModel(input int s, input logic [63:0] x);
        return x ^ rorModel(x, A_ROT[s]) ^ rorModel(x, B_ROT[s]);
    endfunction

    // L^64 is the identity, so 63 forward applications give the inverse.
    function automatic logic [63:0] inverseModel(input int s, input logic [63:0] x);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < 63; i++) y = forwardModel(s, y);
        return y;
    endfunction

    task automatic readOutputs();
        got[0] = oIV;
        got[1] = ok0;
        got[2] = ok1;
        got[3] = on0;
        got[4] = on1;
    endtask

    task automatic checkAllOutputs(input string tag);
        readOutputs();
        for (int s = 0; s < 5; s++)
            checkOutput($sformatf("%s_slot%0d", tag, s), got[s], expW[s]);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        readOutputs();
        for (int s = 0; s < 5; s++)
            checkOutput($sformatf("%s_zero_slot%0d", tag, s), got[s], 64'd0);
    endtask

    task automatic driveWords(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                              input logic [63:0] w3, input logic [63:0] w4);
        IV = w0; k0 = w1; k1 = w2; n0 = w3; n1 = w4;
    endtask

    // Runs one operation on inW; expW must already hold the expected result.
    task automatic applyStimulus(input bit preReady, input int stall, input bit busyPulse);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        driveWords(inW[0], inW[1], inW[2], inW[3], inW[4]);
        in_valid  = 1'b1;
        out_ready = preReady;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            if (cnt == 2) begin
                checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
                if (busyPulse) begin
                    driveWords(~inW[0], ~inW[1], ~inW[2], ~inW[3], ~inW[4]);
                    in_valid = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        checkOutput("latency", 64'(cnt), 64'd6);
        checkAllOutputs("result");
        if (!preReady) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
                checkAllOutputs("stall_hold");
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("post_handshake_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_handshake_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic randomWords();
        for (int s = 0; s < 5; s++) begin
            inW[s]  = {$urandom, $urandom};
            expW[s] = inverseModel(s, inW[s]);
        end
    endtask

    initial begin
        logic [63:0] fwd;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
            checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
            checkOutput("idle_outputs", oIV | ok0 | ok1 | on0 | on1, 64'd0);
        end

        inW  = '{64'd0, 64'd0, 64'h8400000000000001, 64'd0, 64'd0};
        expW = '{64'd0, 64'd0, 64'h0000000000000001, 64'd0, 64'd0};
        applyStimulus(1'b0, 0, 1'b0);

        for (int s = 0; s < 5; s++) begin
            inW[s]  = '1;
            expW[s] = '1;
        end
        applyStimulus(1'b1, 0, 1'b0);

        for (int s = 0; s < 5; s++) begin
            inW[s]  = '0;
            expW[s] = '0;
        end
        applyStimulus(1'b0, 2, 1'b0);

        randomWords();
        applyStimulus(1'b0, 10, 1'b0);

        randomWords();
        applyStimulus(1'b0, 1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_spurious_capture", 64'(out_valid), 64'd0);
            checkOutput("no_spurious_busy", 64'(in_ready), 64'd1);
        end

        // Abort with step 3 pending, then verify a clean restart.
        randomWords();
        driveWords(inW[0], inW[1], inW[2], inW[3], inW[4]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("midrun_reset");
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checkOutput("after_abort_out_valid", 64'(out_valid), 64'd0);
        end
        randomWords();
        applyStimulus(1'b0, 0, 1'b0);

        for (int v = 0; v < 1000; v++) begin
            randomWords();
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0);
            for (int s = 0; s < 5; s++) begin
                fwd = forwardModel(s, got[s]);
                checkOutput($sformatf("roundtrip_slot%0d", s), fwd, inW[s]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
